// File: rtl/gnss_acq_pkg.sv
// Shared acquisition definitions: default datapath widths and the Doppler
// sweep controller state encoding.
package gnss_acq_pkg;

    localparam int OMEGA_W  = 10;
    localparam int DWELL_W  = 16;
    localparam int BIN_W    = 8;
    localparam int ENERGY_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DWELL,
        WAIT_E,
        NEXT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/acq_peak_tracker.sv
// Peak tracker: holds the best energy and its tag (value and index) using a strict
// greater-than compare, so the earliest candidate wins a tie.
module acq_peak_tracker #(
    parameter int VAL_W    = 10,
    parameter int IDX_W    = 8,
    parameter int ENERGY_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                update,
    input  logic                force_update,
    input  logic [ENERGY_W-1:0] energy,
    input  logic [VAL_W-1:0]    tag_val,
    input  logic [IDX_W-1:0]    tag_idx,
    output logic [ENERGY_W-1:0] best_energy,
    output logic [VAL_W-1:0]    best_val,
    output logic [IDX_W-1:0]    best_idx
);

    // NOTE: registers update with non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_energy <= '0;
            best_val    <= '0;
            best_idx    <= '0;
        end else if (clear) begin
            best_energy <= '0;
            best_val    <= '0;
            best_idx    <= '0;
        end else if (update && (force_update || energy > best_energy)) begin
            best_energy <= energy;
            best_val    <= tag_val;
            best_idx    <= tag_idx;
        end
    end

endmodule

// File: rtl/doppler_search_sched.sv
// Doppler-bin sweep controller: steps the NCO frequency word per bin, gates the
// correlator for a fixed dwell, and tracks the peak-energy bin.
// Optional early stop on energy threshold: define DOPPLER_SCHED_THRESH_EN.
module doppler_search_sched #(
    parameter int OMEGA_W  = gnss_acq_pkg::OMEGA_W,
    parameter int DWELL_W  = gnss_acq_pkg::DWELL_W,
    parameter int BIN_W    = gnss_acq_pkg::BIN_W,
    parameter int ENERGY_W = gnss_acq_pkg::ENERGY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OMEGA_W-1:0]  omega_start,
    input  logic [OMEGA_W-1:0]  omega_step,
    input  logic [BIN_W-1:0]    num_bins,
    input  logic [DWELL_W-1:0]  dwell_len,
    input  logic                sample_en,
    input  logic [ENERGY_W-1:0] energy,
    input  logic                energy_valid,
`ifdef DOPPLER_SCHED_THRESH_EN
    input  logic [ENERGY_W-1:0] thresh,
`endif
    output logic [OMEGA_W-1:0]  omega,
    output logic                nco_clear,
    output logic                acc_clear,
    output logic                acc_en,
    output logic                busy,
    output logic                done,
    output logic [OMEGA_W-1:0]  best_omega,
    output logic [BIN_W-1:0]    best_idx,
    output logic [ENERGY_W-1:0] best_energy
);

    import gnss_acq_pkg::*;

    sched_state_t       state, state_nxt;
    logic [OMEGA_W-1:0] omega_q, step_q;
    logic [BIN_W-1:0]   idx_q, last_idx_q;
    logic [DWELL_W-1:0] cnt_q, dwell_last_q;
    logic               accept, e_take, last_bin, dwell_end, thresh_hit;

    assign accept    = (state == IDLE) && start;
    assign e_take    = (state == WAIT_E) && energy_valid;
    assign last_bin  = (idx_q == last_idx_q);
    assign dwell_end = sample_en && (cnt_q == dwell_last_q);

`ifdef DOPPLER_SCHED_THRESH_EN
    logic [ENERGY_W-1:0] thresh_q;
    assign thresh_hit = (energy >= thresh_q);
`else
    assign thresh_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: state_nxt takes its default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = DWELL;
            DWELL:   if (dwell_end) state_nxt = WAIT_E;
            WAIT_E:  if (energy_valid) state_nxt = (last_bin || thresh_hit) ? DONE : NEXT;
            NEXT:    state_nxt = LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero counts are folded to one here so the run-time compares stay simple.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            omega_q      <= '0;
            step_q       <= '0;
            idx_q        <= '0;
            last_idx_q   <= '0;
            cnt_q        <= '0;
            dwell_last_q <= '0;
`ifdef DOPPLER_SCHED_THRESH_EN
            thresh_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    omega_q      <= omega_start;
                    step_q       <= omega_step;
                    idx_q        <= '0;
                    last_idx_q   <= (num_bins == '0) ? '0 : num_bins - BIN_W'(1);
                    dwell_last_q <= (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
`ifdef DOPPLER_SCHED_THRESH_EN
                    thresh_q     <= thresh;
`endif
                end
                LOAD:  cnt_q <= '0;
                DWELL: if (sample_en && !dwell_end) cnt_q <= cnt_q + DWELL_W'(1);
                NEXT: begin
                    omega_q <= omega_q + step_q;
                    idx_q   <= idx_q + BIN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign omega     = omega_q;
    assign nco_clear = (state == LOAD);
    assign acc_clear = (state == LOAD);
    assign acc_en    = (state == DWELL) && sample_en;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    acq_peak_tracker #(
        .VAL_W    (OMEGA_W),
        .IDX_W    (BIN_W),
        .ENERGY_W (ENERGY_W)
    ) u_peak (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .update       (e_take),
        .force_update ((idx_q == '0) || thresh_hit),
        .energy       (energy),
        .tag_val      (omega_q),
        .tag_idx      (idx_q),
        .best_energy  (best_energy),
        .best_val     (best_omega),
        .best_idx     (best_idx)
    );

endmodule

// File: tb/tb_doppler_search_sched.sv
// Scoreboard bench for doppler_search_sched: a sweep-level reference model queues
// expected bin frequencies and peak results; a monitor checks them as the DUT emits.
module tb_doppler_search_sched;

    localparam int OW = 10;
    localparam int DW = 16;
    localparam int BW = 8;
    localparam int EW = 24;

    logic          clk, rst, start, sample_en, energy_valid;
    logic [OW-1:0] omega_start, omega_step, omega, best_omega;
    logic [BW-1:0] num_bins, best_idx;
    logic [DW-1:0] dwell_len;
    logic [EW-1:0] energy, best_energy;
    logic          nco_clear, acc_clear, acc_en, busy, done;
`ifdef DOPPLER_SCHED_THRESH_EN
    logic [EW-1:0] thresh;
`endif

    doppler_search_sched #(
        .OMEGA_W (OW), .DWELL_W (DW), .BIN_W (BW), .ENERGY_W (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .omega_start  (omega_start),
        .omega_step   (omega_step),
        .num_bins     (num_bins),
        .dwell_len    (dwell_len),
        .sample_en    (sample_en),
        .energy       (energy),
        .energy_valid (energy_valid),
`ifdef DOPPLER_SCHED_THRESH_EN
        .thresh       (thresh),
`endif
        .omega        (omega),
        .nco_clear    (nco_clear),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .busy         (busy),
        .done         (done),
        .best_omega   (best_omega),
        .best_idx     (best_idx),
        .best_energy  (best_energy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] om;
        logic [BW-1:0] idx;
        logic [EW-1:0] e;
    } result_t;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [OW-1:0] exp_omega_q[$];
    result_t       exp_res_q[$];
    int            exp_dwell = 1;
    int            done_cnt = 0;
    int            samp_period = 1;
    logic [EW-1:0] en_tbl [0:255];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Free-running sample strobe: high one cycle in every samp_period.
    initial begin
        int cyc = 0;
        sample_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            sample_en = ((cyc % samp_period) == 0);
        end
    end

    // Monitor: one expected omega per bin load, one expected result per done pulse.
    int      acc_cnt = 0;
    bit      bin_open = 0;
    result_t mon_r;
    always @(negedge clk) begin
        if (rst) begin
            if (nco_clear || acc_clear) begin
                check("acc_clear_eq_nco_clear", acc_clear, nco_clear);
                check("busy_in_load", busy, 1);
                if (bin_open) check("acc_en_per_bin", acc_cnt, exp_dwell);
                if (exp_omega_q.size() == 0) check("unexpected_bin_load", nco_clear, 0);
                else check("omega_at_load", $signed(omega), $signed(exp_omega_q.pop_front()));
                acc_cnt  = 0;
                bin_open = 1;
            end
            if (acc_en) acc_cnt++;
            if (done) begin
                done_cnt++;
                if (bin_open) check("acc_en_per_bin", acc_cnt, exp_dwell);
                bin_open = 0;
                check("bins_left_at_done", exp_omega_q.size(), 0);
                if (exp_res_q.size() == 0) check("unexpected_done", done, 0);
                else begin
                    mon_r = exp_res_q.pop_front();
                    check("best_idx", best_idx, mon_r.idx);
                    check("best_omega", $signed(best_omega), $signed(mon_r.om));
                    check("best_energy", best_energy, mon_r.e);
                end
            end
        end else begin
            acc_cnt  = 0;
            bin_open = 0;
        end
    end

    task automatic reset_flush();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        energy_valid = 1'b0;
        exp_omega_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_sweep(input int ostart, input int ostep, input int nb, input int dl,
                             input int period, input logic [EW-1:0] th, input bit disturb);
        int            nbe, dle, loaded, bi, d0, seen, guard, dly;
        logic [EW-1:0] be;
        logic [OW-1:0] om;
        result_t       r;
        bit            disturbed;
        nbe = (nb == 0) ? 1 : nb;
        dle = (dl == 0) ? 1 : dl;
        // Reference: earliest strict maximum; a threshold hit forces that bin and stops.
        loaded = nbe;
        bi = 0;
        be = en_tbl[0];
        for (int k = 0; k < nbe; k++) begin
`ifdef DOPPLER_SCHED_THRESH_EN
            if (en_tbl[k] >= th) begin
                bi = k;
                be = en_tbl[k];
                loaded = k + 1;
                break;
            end
`endif
            if (k == 0 || en_tbl[k] > be) begin
                bi = k;
                be = en_tbl[k];
            end
        end
        for (int k = 0; k < loaded; k++) begin
            om = OW'(ostart + k * ostep);
            exp_omega_q.push_back(om);
        end
        r.om  = OW'(ostart + bi * ostep);
        r.idx = BW'(bi);
        r.e   = be;
        exp_res_q.push_back(r);
        exp_dwell   = dle;
        samp_period = period;
        d0 = done_cnt;

        @(posedge clk);
        #1;
        start       = 1'b1;
        omega_start = OW'(ostart);
        omega_step  = OW'(ostep);
        num_bins    = BW'(nb);
        dwell_len   = DW'(dl);
`ifdef DOPPLER_SCHED_THRESH_EN
        thresh      = th;
`endif
        @(posedge clk);
        #1;
        start       = 1'b0;
        omega_start = OW'($urandom);
        omega_step  = OW'($urandom);
        num_bins    = BW'($urandom);
        dwell_len   = DW'($urandom);
`ifdef DOPPLER_SCHED_THRESH_EN
        thresh      = EW'($urandom_range(0, 3));
`endif

        for (int b = 0; b < loaded; b++) begin
            seen = 0;
            guard = 0;
            disturbed = 0;
            while (seen < dle && guard < 500) begin
                @(negedge clk);
                guard++;
                if (acc_en) seen++;
                if (disturb && b == 0 && seen == 1 && !disturbed) begin
                    start        = 1'b1;
                    omega_start  = OW'($urandom);
                    energy_valid = 1'b1;
                    energy       = '1;
                    disturbed    = 1;
                end else begin
                    start        = 1'b0;
                    energy_valid = 1'b0;
                end
            end
            if (guard >= 500) begin
                check("dwell_timeout", seen, dle);
                reset_flush();
                return;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            energy_valid = 1'b0;
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                @(posedge clk);
                #1;
            end
            energy       = en_tbl[b];
            energy_valid = 1'b1;
            @(posedge clk);
            #1;
            energy_valid = 1'b0;
            energy       = EW'($urandom);
        end

        guard = 0;
        while (done_cnt == d0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt == d0) begin
            check("done_timeout", done_cnt - d0, 1);
            reset_flush();
            return;
        end
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int nb, dl;
        rst = 1'b0;
        start = 1'b0;
        energy_valid = 1'b0;
        energy = '0;
        omega_start = '0;
        omega_step = '0;
        num_bins = '0;
        dwell_len = '0;
`ifdef DOPPLER_SCHED_THRESH_EN
        thresh = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_omega", omega, 0);
        check("rst_nco_clear", nco_clear, 0);
        check("rst_acc_clear", acc_clear, 0);
        check("rst_acc_en", acc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_omega", best_omega, 0);
        check("rst_best_idx", best_idx, 0);
        check("rst_best_energy", best_energy, 0);
        @(negedge clk);
        rst = 1'b1;

        // Ascending energies: last bin wins; omega walks -255..193.
        for (int k = 0; k < 8; k++) en_tbl[k] = EW'(k * 10);
        run_sweep(-255, 64, 8, 4, 1, '1, 0);

        // Tie between bins 1 and 2: earlier bin kept.
        en_tbl[0] = 5; en_tbl[1] = 9; en_tbl[2] = 9; en_tbl[3] = 3;
        run_sweep(17, -3, 4, 2, 1, '1, 0);

        // Frequency word wraps: 500, -424, -324.
        for (int k = 0; k < 3; k++) en_tbl[k] = EW'($urandom_range(0, 1000));
        run_sweep(500, 100, 3, 3, 2, '1, 0);

        // Zero bins and zero dwell both act as one.
        en_tbl[0] = 42;
        run_sweep(-7, 5, 0, 0, 3, '1, 0);

        // Start and stray energy_valid during dwell are ignored.
        for (int k = 0; k < 4; k++) en_tbl[k] = EW'($urandom_range(1, 200));
        run_sweep(-100, 33, 4, 5, 1, '1, 1);

`ifdef DOPPLER_SCHED_THRESH_EN
        // Threshold stops after bin 1; bin 2 never loaded.
        en_tbl[0] = 10; en_tbl[1] = 60; en_tbl[2] = 90;
        run_sweep(0, 40, 3, 3, 1, 50, 0);
`endif

        // Reset mid-dwell: outputs return to zero and no done follows.
        begin
            int seen = 0, guard = 0, d0;
            samp_period = 1;
            exp_dwell = 6;
            exp_omega_q.push_back(OW'(123));
            d0 = done_cnt;
            @(posedge clk);
            #1;
            start = 1'b1; omega_start = OW'(123); omega_step = OW'(9);
            num_bins = BW'(3); dwell_len = DW'(6);
            @(posedge clk);
            #1;
            start = 1'b0;
            while (seen < 2 && guard < 50) begin
                @(negedge clk);
                guard++;
                if (acc_en) seen++;
            end
            check("acc_en_before_reset", seen, 2);
            rst = 1'b0;
            #1;
            check("midrst_busy", busy, 0);
            check("midrst_omega", omega, 0);
            check("midrst_acc_en", acc_en, 0);
            check("midrst_done", done, 0);
            check("midrst_best_energy", best_energy, 0);
            exp_omega_q.delete();
            exp_res_q.delete();
            @(negedge clk);
            rst = 1'b1;
            repeat (30) @(negedge clk);
            check("no_done_after_reset", done_cnt - d0, 0);
            check("idle_after_reset", busy, 0);
        end

        // Randomised sweeps; narrow energy range to exercise ties.
        for (int t = 0; t < 25; t++) begin
            nb = $urandom_range(0, 12);
            dl = $urandom_range(0, 6);
            for (int k = 0; k < 13; k++)
                en_tbl[k] = (t % 2 == 0) ? EW'($urandom_range(0, 15)) : EW'($urandom);
            run_sweep($urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
                      nb, dl, $urandom_range(1, 3),
                      (t % 3 == 0) ? EW'($urandom_range(0, 15)) : '1, (t % 5 == 0) && dl >= 3);
        end

        repeat (5) @(negedge clk);
        check("sb_results_drained", exp_res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/doppler_search_sched.md
# doppler_search_sched

Doppler-bin sweep controller for the acquisition front end. Programs the carrier Doppler NCO frequency word for each search bin and clears its phase at each bin start. Gates the correlator/accumulator for a fixed dwell of sample strobes, then collects one energy result per bin. Reports the bin with peak energy to the acquisition FSM.

## Interface
- OMEGA_W, 10, width of signed NCO frequency word (matches NCO phase accumulator)
- DWELL_W, 16, width of dwell sample counter
- BIN_W, 8, width of bin count/index
- ENERGY_W, 24, width of unsigned correlation energy
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle sweep request; honoured only in IDLE
- omega_start  in  OMEGA_W  signed first-bin frequency word; sampled on accepted start
- omega_step  in  OMEGA_W  signed per-bin increment; sampled on accepted start
- num_bins  in  BIN_W  bins to sweep; 0 treated as 1
- dwell_len  in  DWELL_W  sample strobes per bin; 0 treated as 1
- sample_en  in  1  input sample strobe (NCO advance rate)
- energy  in  ENERGY_W  bin energy from correlator
- energy_valid  in  1  energy qualifier; ignored outside WAIT_E
- omega  out  OMEGA_W  frequency word to NCO
- nco_clear  out  1  one-cycle NCO phase/carry clear at each bin start
- acc_clear  out  1  one-cycle correlator accumulator clear, coincident with nco_clear
- acc_en  out  1  accumulate enable = sample_en while in DWELL
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sweep completion
- best_omega  out  OMEGA_W  frequency word of peak bin
- best_idx  out  BIN_W  index (0-based) of peak bin
- best_energy  out  ENERGY_W  peak energy

## Operation
- States: IDLE, LOAD, DWELL, WAIT_E, NEXT, DONE.
- IDLE: start=1 -> latch omega_start/omega_step/num_bins/dwell_len; omega<=omega_start, bin index<=0, best_energy<=0; -> LOAD.
- LOAD (1 cycle): nco_clear=acc_clear=1; dwell counter<=0; -> DWELL.
- DWELL: each sample_en increments counter; strobe when counter==dwell_len-1 -> WAIT_E (that strobe still accumulated).
- WAIT_E: hold until energy_valid. If energy > best_energy (strict; earliest bin wins ties) or first bin: update best_*. Last bin -> DONE, else -> NEXT.
- NEXT (1 cycle): omega<=omega+omega_step, index+1; -> LOAD.
- DONE (1 cycle): done=1; -> IDLE. best_* hold until next accepted start.
- Omega arithmetic two's complement, wraps modulo 2^OMEGA_W with no saturation, identical to NCO accumulator wrap.
- start while busy ignored; energy_valid outside WAIT_E ignored.
- Reset values: omega=0, nco_clear=acc_clear=acc_en=0, busy=0, done=0, best_omega=0, best_idx=0, best_energy=0, state IDLE.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse.

## Timing
- start at edge t -> busy, nco_clear, acc_clear, new omega all visible after edge t+1 (LOAD); first countable sample_en at edge t+2.
- acc_en combinational from state and sample_en, zero latency.
- Minimum bin period: dwell_len strobes + 1 (WAIT_E with energy_valid immediate) + 1 NEXT + 1 LOAD cycles.
- best_* updated on the edge energy_valid is sampled in WAIT_E; valid when done pulses.
- Counter never exceeds dwell_len-1; no wrap in DWELL_W.

## Configuration
- DOPPLER_SCHED_THRESH_EN defined: adds input thresh [ENERGY_W], sampled on start; energy >= thresh in WAIT_E ends sweep early -> DONE with that bin as best (update forced).
- Undefined: no thresh port; full sweep always performed.

## Structure
- Shared package gnss_acq_pkg: state enum sched_state_t, default width localparams (OMEGA_W, DWELL_W, BIN_W, ENERGY_W).
- Sub-module acq_peak_tracker: clear/update inputs, holds best energy/omega/idx with strict-greater compare; reused by code-phase search.

## Test plan
- omega_start=-255, step=64, num_bins=8, dwell_len=4, sample_en always 1, energy=bin*10 -> omega sequence -255,-191,...,193; done once; best_idx=7, best_omega=193, best_energy=70.
- Energies 5,9,9,3 over 4 bins -> best_idx=1 (tie keeps earlier), best_energy=9.
- omega_start=500, step=100, num_bins=3 -> omega 500, -424, -324 (10-bit wrap).
- num_bins=0, dwell_len=0, sample_en every 3rd cycle -> exactly one bin, one acc_en pulse, done after energy_valid.
- start re-asserted during DWELL and stray energy_valid during DWELL -> no effect; reset low mid-DWELL -> busy=0, omega=0, no done.
- DOPPLER_SCHED_THRESH_EN, thresh=50, energies 10,60,90 -> done after bin 1, best_energy=60, bin 2 never loaded.
